fifo_wr_arbiter: RTL

- Shares one fifo_sync write port between NUM_REQ producers using round-robin, burst-based arbitration.
- Each producer uses a valid/ready/last stream handshake.
- The arbiter drives the FIFO's wr_en/din directly and watches its full/count outputs to throttle producers and gate new grants.
- It sits between the producer blocks and the FIFO instance in the buffering subsystem.

---
 rtl/fifo_ctrl_pkg.sv | 28 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO write-side control blocks.
// Holds the arbiter state encoding, the width helpers and the one-hot decode.
package fifo_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 8;

  // Owner index width; never less than one bit, so NUM_REQ=2 still gets a real index.
  function automatic int idx_width(input int n);
    idx_width = (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int max_burst);
    cnt_width = $clog2(max_burst) + 1;
  endfunction

  localparam int IDX_W_DEFAULT = 2;
  localparam int CNT_W_DEFAULT = 3;

  function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
    onehot = (idx >= 0 && idx < n) ? (MAX_REQ'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above last_grant, with wrap.
// The caller decides when the winner is actually taken.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last_grant) + k) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(last_grant) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-based arbiter sharing one FIFO write port among NUM_REQ producers.
// Handshake: a beat transfers on a rising edge where req_valid[i] && req_ready[i]; data/last hold until then.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int MAX_BURST  = 4,
  parameter int MIN_FREE   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic [$clog2(DEPTH):0]        fifo_count,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = cnt_width(MAX_BURST);
  localparam int FW = $clog2(DEPTH) + 1;

  arb_state_e          state;
  logic [IW-1:0]       owner;
  logic [IW-1:0]       last_grant;
  logic [CW-1:0]       beat_cnt;
  logic [IW-1:0]       win_idx;
  logic                win_found;
  logic [FW-1:0]       free_slots;
  logic                eligible;
  logic                in_burst;
  logic                owner_valid;
  logic                owner_last;
  logic                beat;
  logic                release_burst;
  logic [MAX_REQ-1:0]  owner_oh;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .idx        (win_idx),
    .found      (win_found)
  );

  // fifo_count never exceeds DEPTH, so the unsigned subtraction cannot wrap.
  assign free_slots = FW'(DEPTH) - fifo_count;
  assign eligible   = win_found && (free_slots >= FW'(MIN_FREE));

  assign in_burst    = (state == BURST);
  assign owner_valid = req_valid[owner];
  assign owner_last  = req_last[owner];
  assign beat        = in_burst && owner_valid && !fifo_full;
  assign owner_oh    = onehot(int'(owner), NUM_REQ);
  assign busy        = in_burst;

  // A full FIFO stalls the burst without releasing it; only a valid drop with no beat releases early.
  assign release_burst = in_burst &&
                         ((beat && (owner_last || beat_cnt == CW'(MAX_BURST - 1))) || !owner_valid);

  always_comb begin
    grant      = '0;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (in_burst) begin
      grant            = owner_oh[NUM_REQ-1:0];
      req_ready[owner] = !fifo_full;
      fifo_wr_en       = beat;
      fifo_din         = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (eligible) begin
            owner      <= win_idx;
            last_grant <= win_idx;
            beat_cnt   <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (beat) beat_cnt <= beat_cnt + CW'(1);
          if (release_burst) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
